// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: FSM state type, frame constants and the
// scan-code prefixes also used by the downstream decoder.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the raw PS/2 pins plus a one-cycle pulse on each
// falling edge of the synchronised PS/2 clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_ps2_data,
  output logic o_fall
);

  logic r_clk_meta, r_clk_sync, r_clk_prev;
  logic r_data_meta, r_data_sync;

  // Everything resets to the idle-high level so leaving reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value,
      // which is what builds the shift chain; blocking would collapse it into one flop.
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  assign o_ps2_data = r_data_sync;
  assign o_fall     = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks odd parity and
// queues good bytes in a small FIFO drained by an active-low pop strobe.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic          w_ps2_data, w_fall;
  ps2_rx_state_t r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_timer;
  logic          r_frame_err;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_ps2_data (w_ps2_data),
    .o_fall     (w_fall)
  );

  logic w_frame_good, w_push;
  assign w_frame_good = w_ps2_data & odd_parity_ok(r_shift, r_parity);
  assign w_push       = w_fall & (r_state == STOP) & w_frame_good;

  // Frame deframer; the timer only runs mid-frame and restarts on every PS/2 clock fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_timer     <= '0;
      r_frame_err <= 1'b0;
    end else if (w_fall) begin
      r_timer <= '0;
      case (r_state)
        IDLE: if (!w_ps2_data) begin
          r_state  <= DATA;
          r_bitcnt <= '0;
        end
        DATA: begin
          r_shift  <= {w_ps2_data, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) r_state <= PARITY;
        end
        PARITY: begin
          r_parity <= w_ps2_data;
          r_state  <= STOP;
        end
        STOP: begin
          if (!w_frame_good) r_frame_err <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end else if (r_state != IDLE) begin
      if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
        r_state <= IDLE;
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_next;
  logic          r_ready, r_overflow;
  logic          w_pop, w_full, w_wr_en;

  assign w_pop   = r_ready & ~nextdata_n;
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wr_en = w_push & (~w_full | w_pop);

  always_comb begin
    // NOTE: assigning a default before the ifs keeps this purely combinational (no latch).
    w_count_next = r_count;
    if (w_wr_en && !w_pop)      w_count_next = r_count + CW'(1);
    else if (!w_wr_en && w_pop) w_count_next = r_count - CW'(1);
  end

  // NOTE: the storage array has no reset; pointers and count define what is valid,
  // and leaving it unreset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_wr_en) r_overflow <= 1'b1;
      r_count <= w_count_next;
      r_ready <= (w_count_next != '0);
    end
  end

  assign data      = r_mem[r_rd_ptr];
  assign ready     = r_ready;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: a PS/2 device model sends frames, a queue-based
// reference FIFO predicts the bytes and flags, and a monitor pops and compares.
module tb_ps2_rx_fifo;

  localparam int DEPTH       = 8;
  localparam int TIMEOUT_CYC = 400;
  localparam int HALF        = 20;   // clk cycles per half PS/2 clock period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready, overflow, frame_err;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf  = 1'b0;
  bit         exp_ferr = 1'b0;
  bit         pop_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Device-side frame: start, 8 data LSB first, odd parity, stop. The reference
  // FIFO is updated at the stop-bit fall, the moment the byte is complete.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit chk_lat);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        if (bad_par)                    exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH)  exp_q.push_back(b);
        else                            exp_ovf = 1'b1;
        if (chk_lat) begin
          int n;
          n = 0;
          while (!ready && n < 4) begin
            @(posedge clk); #1;
            n++;
          end
          check("ready_within_4_clk", ready, 1);
        end
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    pop_en = 1'b1;
    while ((ready || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({name, "_ready_low"}, ready, 0);
    check({name, "_all_bytes_seen"}, exp_q.size(), 0);
    pop_en = 1'b0;
  endtask

  // Monitor: pops whenever allowed and the DUT presents a byte.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_en && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %0h expected none", data);
        end else begin
          check("pop_data", data, exp_q.pop_front());
        end
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] seq4 [4];
    seq4 = '{8'hF0, 8'h1C, 8'hE0, 8'h75};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", ready, 0);
    check("reset_overflow", overflow, 0);
    check("reset_frame_err", frame_err, 0);

    // Single frame, latency and head byte
    send_frame(8'h1C, 1'b0, 11, 1'b1);
    check("t1_data", data, 8'h1C);
    drain("t1");

    // Four bytes queued, drained in order
    foreach (seq4[i]) send_frame(seq4[i], 1'b0, 11, 1'b0);
    check("t2_ready", ready, 1);
    drain("t2");

    // Partial frame abandoned by timeout
    send_frame(8'hAA, 1'b0, 5, 1'b0);
    repeat (TIMEOUT_CYC + 50) @(negedge clk);
    send_frame(8'h75, 1'b0, 11, 1'b0);
    check("t5_data", data, 8'h75);
    check("t5_frame_err", frame_err, 0);
    drain("t5");

    // Parity error drops the frame and sets the sticky flag
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    check("t3_ready_after_bad", ready, 0);
    check("t3_frame_err", frame_err, 1);
    send_frame(8'h32, 1'b0, 11, 1'b0);
    check("t3_data", data, 8'h32);
    drain("t3");

    // Overflow: nine frames into eight entries
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 11, 1'b0);
    check("t4_overflow", overflow, 1);
    check("t4_data_head", data, 8'h01);
    drain("t4");

    // Reset mid-frame with bytes queued
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 11, 1'b0);
    send_frame(8'h5A, 1'b0, 5, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_ready", ready, 0);
    check("t6_overflow", overflow, 0);
    check("t6_frame_err", frame_err, 0);
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    send_frame(8'h29, 1'b0, 11, 1'b0);
    check("t6_data", data, 8'h29);
    drain("t6");

    // Randomised traffic with occasional parity errors and consumer stalls
    for (int i = 0; i < 24; i++) begin
      pop_en = ($urandom_range(0, 2) != 0);
      send_frame(8'($urandom), ($urandom_range(0, 7) == 0), 11, 1'b0);
    end
    drain("rand");
    check("rand_overflow", overflow, exp_ovf);
    check("rand_frame_err", frame_err, exp_ferr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
